// File: rtl/dct_pkg.sv
// Shared definitions for the DCT coefficient path: bank lifecycle states and
// the JPEG zigzag scan table (entries are row*8+col).
package dct_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_t;

  localparam int          ROWS     = 8;
  localparam logic [2:0]  LAST_ROW = 3'd7;
  localparam logic [5:0]  LAST_IDX = 6'd63;

  localparam logic [5:0] ZIGZAG [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage

// File: rtl/coef_bank.sv
// One 8x8 coefficient bank: a whole row is written per cycle, single words are
// read combinationally. Storage is deliberately not reset.
module coef_bank
  import dct_pkg::*;
#(
  parameter int W = 16
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [2:0]      wr_row,
  input  logic [8*W-1:0]  wr_data,
  input  logic [5:0]      rd_addr,
  output logic [W-1:0]    rd_data
);

  logic [W-1:0] mem_r [64];

  // Row write: column c of the packed row lands at address row*8+c.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int c = 0; c < ROWS; c++) begin
        mem_r[{wr_row, 3'(c)}] <= wr_data[c*W +: W];
      end
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/dct_coef_serializer.sv
// Ping-pong row-to-zigzag serializer: rows of DCT coefficients fill one bank
// while the other bank is streamed out in JPEG zigzag order.
module dct_coef_serializer
  import dct_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] z0,
  input  logic signed [W-1:0] z1,
  input  logic signed [W-1:0] z2,
  input  logic signed [W-1:0] z3,
  input  logic signed [W-1:0] z4,
  input  logic signed [W-1:0] z5,
  input  logic signed [W-1:0] z6,
  input  logic signed [W-1:0] z7,
  input  logic                in_valid,
  output logic                in_ready,
  output logic signed [W-1:0] out_data,
  output logic [5:0]          out_idx,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic [15:0]         blk_cnt
);

  bank_state_t st_r [2];
  bank_state_t upd_s [2];
  bank_state_t st_s [2];
  logic        wr_bank_r, rd_bank_r;
  logic        wr_bank_s, rd_bank_s;
  logic [2:0]  row_cnt_r;
  logic [5:0]  idx_s;
  logic [5:0]  rd_addr_s;
  logic        in_beat_s, out_hs_s, last_hs_s;
  logic [8*W-1:0] row_s;
  logic [W-1:0]   rd_data_s [2];

  assign in_beat_s = in_valid && in_ready;
  assign out_hs_s  = out_valid && out_ready;
  assign last_hs_s = out_hs_s && (out_idx == LAST_IDX);
  assign row_s     = {z7, z6, z5, z4, z3, z2, z1, z0};
  assign rd_addr_s = ZIGZAG[idx_s];

  // Next bank states; a bank that becomes FULL while it is the read bank goes
  // straight to DRAINING so the first word appears one cycle after row 7.
  always_comb begin
    wr_bank_s = wr_bank_r ^ (in_beat_s && (row_cnt_r == LAST_ROW));
    rd_bank_s = rd_bank_r ^ last_hs_s;
    for (int b = 0; b < 2; b++) begin
      if (in_beat_s && (wr_bank_r == 1'(b))) begin
        upd_s[b] = (row_cnt_r == LAST_ROW) ? BANK_FULL : BANK_FILLING;
      end else if (last_hs_s && (rd_bank_r == 1'(b))) begin
        upd_s[b] = BANK_EMPTY;
      end else begin
        upd_s[b] = st_r[b];
      end
      st_s[b] = ((upd_s[b] == BANK_FULL) && (rd_bank_s == 1'(b))) ? BANK_DRAINING : upd_s[b];
    end
  end

  // Next zigzag position; it returns to 0 when a block completes.
  always_comb begin
    if (last_hs_s) begin
      idx_s = 6'd0;
    end else if (out_hs_s) begin
      idx_s = out_idx + 6'd1;
    end else begin
      idx_s = out_idx;
    end
  end

  coef_bank #(.W(W)) u_bank0 (
    .clk     (clk),
    .wr_en   (rst && in_beat_s && (wr_bank_r == 1'b0)),
    .wr_row  (row_cnt_r),
    .wr_data (row_s),
    .rd_addr (rd_addr_s),
    .rd_data (rd_data_s[0])
  );

  coef_bank #(.W(W)) u_bank1 (
    .clk     (clk),
    .wr_en   (rst && in_beat_s && (wr_bank_r == 1'b1)),
    .wr_row  (row_cnt_r),
    .wr_data (row_s),
    .rd_addr (rd_addr_s),
    .rd_data (rd_data_s[1])
  );

  // Control state and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      st_r[0]   <= BANK_EMPTY;
      st_r[1]   <= BANK_EMPTY;
      wr_bank_r <= 1'b0;
      rd_bank_r <= 1'b0;
      row_cnt_r <= 3'd0;
      out_idx   <= 6'd0;
      blk_cnt   <= 16'd0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      st_r[0]   <= st_s[0];
      st_r[1]   <= st_s[1];
      wr_bank_r <= wr_bank_s;
      rd_bank_r <= rd_bank_s;
      row_cnt_r <= in_beat_s ? (row_cnt_r + 3'd1) : row_cnt_r;
      out_idx   <= idx_s;
      blk_cnt   <= blk_cnt + {15'd0, last_hs_s};
      out_valid <= (st_s[rd_bank_s] == BANK_DRAINING);
      out_last  <= (st_s[rd_bank_s] == BANK_DRAINING) && (idx_s == LAST_IDX);
      in_ready  <= (st_s[wr_bank_s] == BANK_EMPTY) || (st_s[wr_bank_s] == BANK_FILLING);
    end
  end

  // Output word is fetched at the next position so it lines up with out_idx.
  always_ff @(posedge clk) begin
    out_data <= rd_data_s[rd_bank_s];
  end

endmodule
